evr_rx_decoder: RTL and testbench
=================================

Name: evr_rx_decoder

Overview:
- Receive-side counterpart of the event generator.
- Consumes the 16-bit aligned word stream from the event receiver transceiver (one word per evrRxClk).
- Recovers the event code stream, distributed bus, heartbeat/ping pulses and seconds-shift time of day, plus link-lock state and error counting.
- Sits between the transceiver wrapper and downstream trigger/timestamp logic.

Parameters:
- TOD_SECONDS_WIDTH, 32, width of recovered seconds value and of seconds shift register.
- LOCK_COUNT, 64, consecutive error-free words required to declare lock (≥2).
- ERROR_LIMIT, 4, code errors tolerated within one 256-word window before dropping lock.
- TICK_WIDTH, 32, width of ticks-since-seconds-marker counter.

Ports:
- evrRxClk, input, 1, receiver recovered clock; sole clock.
- evrRxReset, input, 1, synchronous active-high reset.
- evrRxData, input, 16, [7:0] event byte, [15:8] distributed bus byte.
- evrRxCharIsK, input, 2, per-byte K-character flags.
- evrRxCodeErr, input, 2, per-byte not-in-table OR disparity error.
- evrLinkUp, output, 1, receiver locked.
- evrEventCode, output, 8, last valid event code.
- evrEventStrobe, output, 1, one-cycle pulse with each valid event code.
- evrDistributedBus, output, 8, last valid distributed bus byte.
- evrHeartbeat, output, 1, one-cycle pulse on distributed bus bit 0 rising edge.
- evrPing, output, 1, one-cycle pulse on distributed bus bit 1 rising edge.
- evrSeconds, output, TOD_SECONDS_WIDTH, recovered seconds.
- evrSecondsValid, output, 1, evrSeconds loaded from a complete shift sequence.
- evrTicks, output, TICK_WIDTH, cycles since last seconds marker, saturating.
- evrCodeErrorCount, output, 16, saturating count of words with any evrRxCodeErr bit set.

Behaviour:
- Reset: all outputs 0; lock FSM to HUNT; shift register and bit count cleared.
- All outputs registered; an input word affects outputs on the following evrRxClk edge (latency 1).
- Word classification:
  - Error word: evrRxCodeErr≠0.
  - Valid word: no error and evrRxCharIsK[1]=0.
  - Event byte 0xBC with CharIsK[0]=1 is idle comma: no event.
  - Any other K in byte 0 is ignored.
- Lock FSM:
  - HUNT: count consecutive valid words; any error or CharIsK[1]=1 restarts the count at 0; reaching LOCK_COUNT goes to LOCKED, evrLinkUp=1 next cycle.
  - LOCKED: a 256-word free-running window counts error words; on the error count exceeding ERROR_LIMIT, go to HUNT, evrLinkUp=0 next cycle, and the window restarts; the window counter clears at wrap.
- Decode outputs are updated only while LOCKED (state at the input cycle); in HUNT, strobes are held 0 and evrDistributedBus holds its value.
- Event decode: a valid word with CharIsK[0]=0 and event byte≠0x00 sets evrEventCode=byte and pulses evrEventStrobe. Code 0x00 is a null event: no strobe.
- Distributed bus: valid word → evrDistributedBus=byte1. evrHeartbeat/evrPing pulse when the new bit=1 and the previous registered bit=0. Bus values from error words are discarded.
- Seconds protocol (evaluated on event codes):
  - 0x70: shift 0 into the LSB.
  - 0x71: shift 1 into the LSB (MSB first overall); the bit count increments and saturates at TOD_SECONDS_WIDTH+1.
  - 0x7D (seconds marker):
    - If bit count == TOD_SECONDS_WIDTH: evrSeconds=shift register, evrSecondsValid=1.
    - Otherwise: evrSecondsValid=0 and evrSeconds unchanged.
    - Always: bit count=0, evrTicks=0.
  - All three codes also produce evrEventStrobe.
- evrTicks increments every cycle otherwise and saturates at all-ones.
- Leaving LOCKED: evrSecondsValid=0, bit count=0; evrSeconds is retained.
- evrCodeErrorCount counts in all FSM states and saturates at 0xFFFF.
- Simultaneous conditions:
  - An error word in the cycle lock is reached keeps the FSM in HUNT (count restarts).
  - A 0x7D arriving while evrTicks is saturated still clears evrTicks.
- Reset mid-operation: returns to HUNT next cycle regardless of state; any in-progress shift sequence is lost.

Test Plan:
- Reset, then 64 words {0x00,0xBC}, K=01, no errors → evrLinkUp rises one cycle after the 64th word; no evrEventStrobe asserted.
- Locked link, word 0x0127 (K=00) → evrEventCode=0x27, evrEventStrobe for exactly one cycle, evrDistributedBus=0x01, evrHeartbeat one pulse; repeating the word gives no further heartbeat.
- Shift 32 codes encoding 0x12345678 MSB first, then 0x7D → evrSeconds=0x12345678, evrSecondsValid=1, evrTicks=0 then increments by 1 per cycle.
- Shift only 31 bits, then 0x7D → evrSecondsValid=0, evrSeconds unchanged, evrTicks reset.
- While locked, inject 5 error words within 256 words → evrLinkUp falls; evrCodeErrorCount=5; events suppressed until 64 clean words relock.
- Assert evrRxReset during a shift sequence → all outputs 0 the next cycle; a fresh full 32-bit sequence after relock loads correctly.

Source files
------------

// File: rtl/evr_rx_decoder_if.sv
// Word stream from the receiver transceiver plus the decoded event/timing outputs.
interface evr_rx_decoder_if #(
  parameter int TOD_SECONDS_WIDTH = 32,
  parameter int TICK_WIDTH        = 32
);
  logic [15:0]                  evrRxData;
  logic [1:0]                   evrRxCharIsK;
  logic [1:0]                   evrRxCodeErr;
  logic                         evrLinkUp;
  logic [7:0]                   evrEventCode;
  logic                         evrEventStrobe;
  logic [7:0]                   evrDistributedBus;
  logic                         evrHeartbeat;
  logic                         evrPing;
  logic [TOD_SECONDS_WIDTH-1:0] evrSeconds;
  logic                         evrSecondsValid;
  logic [TICK_WIDTH-1:0]        evrTicks;
  logic [15:0]                  evrCodeErrorCount;

  // Transceiver side: supplies words, observes decoded results.
  modport master (
    output evrRxData, evrRxCharIsK, evrRxCodeErr,
    input  evrLinkUp, evrEventCode, evrEventStrobe, evrDistributedBus, evrHeartbeat,
           evrPing, evrSeconds, evrSecondsValid, evrTicks, evrCodeErrorCount
  );

  // Decoder side.
  modport slave (
    input  evrRxData, evrRxCharIsK, evrRxCodeErr,
    output evrLinkUp, evrEventCode, evrEventStrobe, evrDistributedBus, evrHeartbeat,
           evrPing, evrSeconds, evrSecondsValid, evrTicks, evrCodeErrorCount
  );
endinterface

// File: rtl/evr_rx_decoder.sv
// Event receiver decoder: link lock, event/dbus decode, seconds time-of-day recovery.
module evr_rx_decoder #(
  parameter int TOD_SECONDS_WIDTH = 32,
  parameter int LOCK_COUNT        = 64,
  parameter int ERROR_LIMIT       = 4,
  parameter int TICK_WIDTH        = 32
) (
  input logic              evrRxClk,
  input logic              evrRxReset,
  evr_rx_decoder_if.slave  rx
);
  localparam int HCW = (LOCK_COUNT > 2) ? $clog2(LOCK_COUNT) : 1;
  localparam int BCW = $clog2(TOD_SECONDS_WIDTH + 2);
  localparam int EW  = $clog2(ERROR_LIMIT + 2);
  localparam logic [7:0] EV_SEC0   = 8'h70;
  localparam logic [7:0] EV_SEC1   = 8'h71;
  localparam logic [7:0] EV_MARKER = 8'h7D;

  typedef enum logic {HUNT, LOCKED} state_e;

  state_e                       state_q, state_d;
  logic [HCW-1:0]               hunt_cnt_q, hunt_cnt_d;
  logic [7:0]                   win_cnt_q, win_cnt_d;
  logic [EW-1:0]                win_err_q, win_err_d;
  logic [7:0]                   code_q, code_d;
  logic                         strobe_q, strobe_d;
  logic [7:0]                   bus_q, bus_d;
  logic                         hb_q, hb_d;
  logic                         ping_q, ping_d;
  logic [TOD_SECONDS_WIDTH-1:0] sec_q, sec_d;
  logic                         sec_vld_q, sec_vld_d;
  logic [TICK_WIDTH-1:0]        ticks_q, ticks_d;
  logic [15:0]                  err_total_q, err_total_d;
  logic [TOD_SECONDS_WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]               bit_cnt_q, bit_cnt_d;

  logic       word_err, word_vld;
  logic [7:0] ev_byte, db_byte;

  assign word_err = |rx.evrRxCodeErr;
  assign word_vld = !word_err && !rx.evrRxCharIsK[1];
  assign ev_byte  = rx.evrRxData[7:0];
  assign db_byte  = rx.evrRxData[15:8];

  // Lock FSM next state plus all decode; decode only acts on words seen while LOCKED.
  always_comb begin
    state_d     = state_q;
    hunt_cnt_d  = hunt_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    code_d      = code_q;
    strobe_d    = 1'b0;
    bus_d       = bus_q;
    hb_d        = 1'b0;
    ping_d      = 1'b0;
    sec_d       = sec_q;
    sec_vld_d   = sec_vld_q;
    ticks_d     = (ticks_q == '1) ? ticks_q : ticks_q + 1'b1;
    err_total_d = (word_err && err_total_q != 16'hFFFF) ? err_total_q + 16'd1 : err_total_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;

    case (state_q)
      HUNT: begin
        win_cnt_d = '0;
        win_err_d = '0;
        if (!word_vld)
          hunt_cnt_d = '0;
        else if (hunt_cnt_q == HCW'(LOCK_COUNT - 1)) begin
          state_d    = LOCKED;
          hunt_cnt_d = '0;
        end else
          hunt_cnt_d = hunt_cnt_q + 1'b1;
      end
      LOCKED: begin
        win_cnt_d = win_cnt_q + 8'd1;
        if (word_err && win_err_q >= EW'(ERROR_LIMIT)) begin
          // Too many errors this window: drop lock, abandon any seconds sequence.
          state_d   = HUNT;
          win_cnt_d = '0;
          win_err_d = '0;
          sec_vld_d = 1'b0;
          bit_cnt_d = '0;
        end else begin
          if (word_err) win_err_d = win_err_q + 1'b1;
          if (win_cnt_q == 8'hFF) win_err_d = '0;
        end

        if (word_vld) begin
          bus_d  = db_byte;
          hb_d   = db_byte[0] && !bus_q[0];
          ping_d = db_byte[1] && !bus_q[1];
          if (!rx.evrRxCharIsK[0] && ev_byte != 8'h00) begin
            code_d   = ev_byte;
            strobe_d = 1'b1;
            if (ev_byte == EV_SEC0 || ev_byte == EV_SEC1) begin
              // Code LSB is the shifted bit; sequence arrives MSB first.
              shift_d = {shift_q[TOD_SECONDS_WIDTH-2:0], ev_byte[0]};
              if (bit_cnt_q != BCW'(TOD_SECONDS_WIDTH + 1)) bit_cnt_d = bit_cnt_q + 1'b1;
            end else if (ev_byte == EV_MARKER) begin
              if (bit_cnt_q == BCW'(TOD_SECONDS_WIDTH)) begin
                sec_d     = shift_q;
                sec_vld_d = 1'b1;
              end else
                sec_vld_d = 1'b0;
              bit_cnt_d = '0;
              ticks_d   = '0;
            end
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge evrRxClk) begin
    if (evrRxReset) begin
      state_q     <= HUNT;
      hunt_cnt_q  <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      code_q      <= '0;
      strobe_q    <= 1'b0;
      bus_q       <= '0;
      hb_q        <= 1'b0;
      ping_q      <= 1'b0;
      sec_q       <= '0;
      sec_vld_q   <= 1'b0;
      ticks_q     <= '0;
      err_total_q <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      hunt_cnt_q  <= hunt_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      code_q      <= code_d;
      strobe_q    <= strobe_d;
      bus_q       <= bus_d;
      hb_q        <= hb_d;
      ping_q      <= ping_d;
      sec_q       <= sec_d;
      sec_vld_q   <= sec_vld_d;
      ticks_q     <= ticks_d;
      err_total_q <= err_total_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  assign rx.evrLinkUp         = (state_q == LOCKED);
  assign rx.evrEventCode      = code_q;
  assign rx.evrEventStrobe    = strobe_q;
  assign rx.evrDistributedBus = bus_q;
  assign rx.evrHeartbeat      = hb_q;
  assign rx.evrPing           = ping_q;
  assign rx.evrSeconds        = sec_q;
  assign rx.evrSecondsValid   = sec_vld_q;
  assign rx.evrTicks          = ticks_q;
  assign rx.evrCodeErrorCount = err_total_q;
endmodule

// File: tb/tb_evr_rx_decoder.sv
// Directed bench for evr_rx_decoder.
module tb_evr_rx_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  evr_rx_decoder_if #(.TOD_SECONDS_WIDTH(32), .TICK_WIDTH(32)) bus ();

  evr_rx_decoder #(
    .TOD_SECONDS_WIDTH(32), .LOCK_COUNT(64), .ERROR_LIMIT(4), .TICK_WIDTH(32)
  ) dut (
    .evrRxClk  (clk),
    .evrRxReset(rst),
    .rx        (bus.slave)
  );

  always #5 clk = ~clk;

  // Drive one word on the falling edge; return just after the rising edge that consumes it.
  task automatic send(input logic [15:0] d, input logic [1:0] k, input logic [1:0] e);
    @(negedge clk);
    bus.evrRxData    = d;
    bus.evrRxCharIsK = k;
    bus.evrRxCodeErr = e;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(16'h00BC, 2'b01, 2'b00);
  endtask

  task automatic shift_bits(input logic [31:0] v, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) send(v[i] ? 16'h0071 : 16'h0070, 2'b00, 2'b00);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    send(16'h00BC, 2'b01, 2'b00);
    send(16'h00BC, 2'b01, 2'b00);
    checks++;
    if (bus.evrLinkUp !== 1'b0 || bus.evrEventStrobe !== 1'b0 || bus.evrEventCode !== 8'h00 ||
        bus.evrDistributedBus !== 8'h00 || bus.evrSeconds !== 32'h0 || bus.evrSecondsValid !== 1'b0 ||
        bus.evrTicks !== 32'h0 || bus.evrCodeErrorCount !== 16'h0) begin
      failures++;
      $display("FAIL reset_state link=%b code=%h sec=%h ticks=%0d errs=%0d (all required 0)",
               bus.evrLinkUp, bus.evrEventCode, bus.evrSeconds, bus.evrTicks, bus.evrCodeErrorCount);
    end
    rst = 1'b0;
  endtask

  task automatic test_lock;
    int strobes = 0;
    for (int i = 0; i < 63; i++) begin
      send(16'h00BC, 2'b01, 2'b00);
      if (bus.evrEventStrobe) strobes++;
    end
    checks++;
    if (bus.evrLinkUp !== 1'b0) begin
      failures++;
      $display("FAIL lock_early link=%b required 0 after 63 words", bus.evrLinkUp);
    end
    send(16'h00BC, 2'b01, 2'b00);
    if (bus.evrEventStrobe) strobes++;
    checks++;
    if (bus.evrLinkUp !== 1'b1) begin
      failures++;
      $display("FAIL lock_reached link=%b required 1 after 64 words", bus.evrLinkUp);
    end
    checks++;
    if (strobes != 0) begin
      failures++;
      $display("FAIL lock_no_strobe strobes=%0d required 0", strobes);
    end
  endtask

  task automatic test_event_heartbeat;
    send(16'h0127, 2'b00, 2'b00);
    checks++;
    if (bus.evrEventCode !== 8'h27 || bus.evrEventStrobe !== 1'b1 ||
        bus.evrDistributedBus !== 8'h01 || bus.evrHeartbeat !== 1'b1 || bus.evrPing !== 1'b0) begin
      failures++;
      $display("FAIL event_first code=%h stb=%b dbus=%h hb=%b ping=%b required 27 1 01 1 0",
               bus.evrEventCode, bus.evrEventStrobe, bus.evrDistributedBus, bus.evrHeartbeat, bus.evrPing);
    end
    send(16'h0127, 2'b00, 2'b00);
    checks++;
    if (bus.evrHeartbeat !== 1'b0 || bus.evrEventStrobe !== 1'b1) begin
      failures++;
      $display("FAIL event_repeat hb=%b stb=%b required 0 1", bus.evrHeartbeat, bus.evrEventStrobe);
    end
    send(16'h0200, 2'b00, 2'b00);
    checks++;
    if (bus.evrPing !== 1'b1 || bus.evrEventStrobe !== 1'b0 || bus.evrEventCode !== 8'h27 ||
        bus.evrDistributedBus !== 8'h02) begin
      failures++;
      $display("FAIL null_event_ping ping=%b stb=%b code=%h dbus=%h required 1 0 27 02",
               bus.evrPing, bus.evrEventStrobe, bus.evrEventCode, bus.evrDistributedBus);
    end
    send(16'h00BC, 2'b01, 2'b00);
    checks++;
    if (bus.evrEventStrobe !== 1'b0 || bus.evrDistributedBus !== 8'h00) begin
      failures++;
      $display("FAIL idle_after stb=%b dbus=%h required 0 00", bus.evrEventStrobe, bus.evrDistributedBus);
    end
  endtask

  task automatic test_seconds;
    shift_bits(32'h12345678, 32);
    send(16'h007D, 2'b00, 2'b00);
    checks++;
    if (bus.evrSeconds !== 32'h12345678 || bus.evrSecondsValid !== 1'b1 || bus.evrTicks !== 32'd0 ||
        bus.evrEventStrobe !== 1'b1 || bus.evrEventCode !== 8'h7D) begin
      failures++;
      $display("FAIL seconds_load sec=%h vld=%b ticks=%0d stb=%b required 12345678 1 0 1",
               bus.evrSeconds, bus.evrSecondsValid, bus.evrTicks, bus.evrEventStrobe);
    end
    idle(1);
    checks++;
    if (bus.evrTicks !== 32'd1) begin
      failures++;
      $display("FAIL ticks_1 ticks=%0d required 1", bus.evrTicks);
    end
    idle(1);
    checks++;
    if (bus.evrTicks !== 32'd2) begin
      failures++;
      $display("FAIL ticks_2 ticks=%0d required 2", bus.evrTicks);
    end
  endtask

  task automatic test_short_seconds;
    shift_bits(32'h0BADF00D, 31);
    send(16'h007D, 2'b00, 2'b00);
    checks++;
    if (bus.evrSeconds !== 32'h12345678 || bus.evrSecondsValid !== 1'b0 || bus.evrTicks !== 32'd0) begin
      failures++;
      $display("FAIL seconds_short sec=%h vld=%b ticks=%0d required 12345678 0 0",
               bus.evrSeconds, bus.evrSecondsValid, bus.evrTicks);
    end
  endtask

  task automatic test_error_drop;
    for (int i = 0; i < 4; i++) send(16'h00BC, 2'b01, 2'b01);
    checks++;
    if (bus.evrLinkUp !== 1'b1) begin
      failures++;
      $display("FAIL err_4_locked link=%b required 1", bus.evrLinkUp);
    end
    send(16'h00BC, 2'b01, 2'b10);
    checks++;
    if (bus.evrLinkUp !== 1'b0 || bus.evrCodeErrorCount !== 16'd5) begin
      failures++;
      $display("FAIL err_5_drop link=%b errs=%0d required 0 5", bus.evrLinkUp, bus.evrCodeErrorCount);
    end
    send(16'h0127, 2'b00, 2'b00);
    checks++;
    if (bus.evrEventStrobe !== 1'b0 || bus.evrHeartbeat !== 1'b0 || bus.evrDistributedBus !== 8'h00 ||
        bus.evrEventCode !== 8'h7D) begin
      failures++;
      $display("FAIL hunt_suppress stb=%b hb=%b dbus=%h code=%h required 0 0 00 7d",
               bus.evrEventStrobe, bus.evrHeartbeat, bus.evrDistributedBus, bus.evrEventCode);
    end
    idle(62);
    checks++;
    if (bus.evrLinkUp !== 1'b0) begin
      failures++;
      $display("FAIL relock_early link=%b required 0 after 63 clean", bus.evrLinkUp);
    end
    idle(1);
    checks++;
    if (bus.evrLinkUp !== 1'b1) begin
      failures++;
      $display("FAIL relock link=%b required 1 after 64 clean", bus.evrLinkUp);
    end
  endtask

  task automatic test_reset_midshift;
    shift_bits(32'hFFFFFFFF, 10);
    @(negedge clk);
    rst = 1'b1;
    send(16'h00BC, 2'b01, 2'b00);
    checks++;
    if (bus.evrLinkUp !== 1'b0 || bus.evrSeconds !== 32'h0 || bus.evrEventCode !== 8'h00 ||
        bus.evrTicks !== 32'h0 || bus.evrCodeErrorCount !== 16'h0 || bus.evrSecondsValid !== 1'b0) begin
      failures++;
      $display("FAIL midshift_reset link=%b sec=%h code=%h ticks=%0d errs=%0d required all 0",
               bus.evrLinkUp, bus.evrSeconds, bus.evrEventCode, bus.evrTicks, bus.evrCodeErrorCount);
    end
    rst = 1'b0;
    // An error arriving on what would be the locking word restarts the hunt.
    idle(63);
    send(16'h00BC, 2'b01, 2'b01);
    checks++;
    if (bus.evrLinkUp !== 1'b0 || bus.evrCodeErrorCount !== 16'd1) begin
      failures++;
      $display("FAIL err_on_lock link=%b errs=%0d required 0 1", bus.evrLinkUp, bus.evrCodeErrorCount);
    end
    idle(64);
    checks++;
    if (bus.evrLinkUp !== 1'b1) begin
      failures++;
      $display("FAIL lock_after_reset link=%b required 1", bus.evrLinkUp);
    end
    shift_bits(32'hA5C30F96, 32);
    send(16'h007D, 2'b00, 2'b00);
    checks++;
    if (bus.evrSeconds !== 32'hA5C30F96 || bus.evrSecondsValid !== 1'b1) begin
      failures++;
      $display("FAIL fresh_seconds sec=%h vld=%b required a5c30f96 1", bus.evrSeconds, bus.evrSecondsValid);
    end
  endtask

  initial begin
    bus.evrRxData    = 16'h00BC;
    bus.evrRxCharIsK = 2'b01;
    bus.evrRxCodeErr = 2'b00;
    test_reset();
    test_lock();
    test_event_heartbeat();
    test_seconds();
    test_short_seconds();
    test_error_drop();
    test_reset_midshift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
